// File: rtl/mir_pkg.sv
// mir_pkg: shared definitions for the microinstruction pipeline register.
// Field widths, microword width helper, field offsets, FSM state enum and
// the NOP microword builder. Microword layout, MSB->LSB:
//   ALUC[4] SH[2] KMux MR MW SelA SelB SelC Type DAdd
package mir_pkg;

  // Default field widths
  localparam int unsigned SELA_W_DEF = 5;
  localparam int unsigned SELB_W_DEF = 6;
  localparam int unsigned SELC_W_DEF = 6;
  localparam int unsigned TYPE_W_DEF = 7;
  localparam int unsigned DADD_W_DEF = 10;

  // Upper bound on the microword width handled by the helper functions
  localparam int unsigned UW_MAX = 256;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } mir_state_e;

  // Total microword width: 9 fixed control bits plus the variable fields
  function automatic int unsigned uw_w(input int unsigned sela_w,
                                       input int unsigned selb_w,
                                       input int unsigned selc_w,
                                       input int unsigned type_w,
                                       input int unsigned dadd_w);
    return 9 + sela_w + selb_w + selc_w + type_w + dadd_w;
  endfunction

  // Field offsets (LSB position of each field)
  function automatic int unsigned off_type(input int unsigned dadd_w);
    return dadd_w;
  endfunction

  function automatic int unsigned off_selc(input int unsigned dadd_w,
                                           input int unsigned type_w);
    return dadd_w + type_w;
  endfunction

  function automatic int unsigned off_selb(input int unsigned dadd_w,
                                           input int unsigned type_w,
                                           input int unsigned selc_w);
    return dadd_w + type_w + selc_w;
  endfunction

  function automatic int unsigned off_sela(input int unsigned dadd_w,
                                           input int unsigned type_w,
                                           input int unsigned selc_w,
                                           input int unsigned selb_w);
    return dadd_w + type_w + selc_w + selb_w;
  endfunction

  // MW sits directly above SelA, followed by MR, KMux, SH and ALUC
  function automatic int unsigned off_mw(input int unsigned dadd_w,
                                         input int unsigned type_w,
                                         input int unsigned selc_w,
                                         input int unsigned selb_w,
                                         input int unsigned sela_w);
    return dadd_w + type_w + selc_w + selb_w + sela_w;
  endfunction

  // Offsets for the default configuration
  localparam int unsigned OFF_SELC_DEF = DADD_W_DEF + TYPE_W_DEF;
  localparam int unsigned OFF_MW_DEF   = DADD_W_DEF + TYPE_W_DEF + SELC_W_DEF
                                         + SELB_W_DEF + SELA_W_DEF;
  localparam int unsigned OFF_MR_DEF   = OFF_MW_DEF + 1;

  // NOP microword: everything zero except SelC, which carries the
  // "write no register" code. Returned at UW_MAX width; callers slice.
  function automatic logic [UW_MAX-1:0] nop_word(input int unsigned selc_off,
                                                 input int unsigned selc_w,
                                                 input int unsigned selc_nop);
    logic [UW_MAX-1:0] mask;
    logic [UW_MAX-1:0] code;
    mask = (UW_MAX'(1) << selc_w) - UW_MAX'(1);
    code = UW_MAX'(selc_nop) & mask;
    return code << selc_off;
  endfunction

endpackage

// File: rtl/mir_field_reg.sv
// mir_field_reg: microword-wide register with load enable, synchronous
// clear-to-NOP and asynchronous clear-to-NOP on reset. Used for both the
// output register and the skid register of the pipeline.
module mir_field_reg
  import mir_pkg::*;
#(
  parameter int unsigned W   = uw_w(SELA_W_DEF, SELB_W_DEF, SELC_W_DEF,
                                    TYPE_W_DEF, DADD_W_DEF),
  parameter logic [W-1:0] NOP = '0
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         LD,
  input  logic         CLR,
  input  logic [W-1:0] D,
  output logic [W-1:0] Q
);

  logic [W-1:0] q_reg;

  // Hold the word; clearing to NOP wins over a load
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q_reg <= NOP;
    end else if (CLR) begin
      q_reg <= NOP;
    end else if (LD) begin
      q_reg <= D;
    end
  end

  assign Q = q_reg;

endmodule

// File: rtl/mir_pipe.sv
// mir_pipe: two-entry skid buffer feeding microwords to the datapath.
// States EMPTY / ONE (output register full) / FULL (output + skid full).
// IN_READY is registered, so a word offered while FULL is simply not taken.
// FLUSH empties the buffer on the next edge and drops any same-cycle input.
// Optional feature: define MIR_PARITY_EN to add the UW_PAR input (even
// parity over UW_IN) and the sticky PAR_ERR output; a word failing parity
// is stored as NOP.
module mir_pipe
  import mir_pkg::*;
#(
  parameter int unsigned SELA_W   = 5,
  parameter int unsigned SELB_W   = 6,
  parameter int unsigned SELC_W   = 6,
  parameter int unsigned TYPE_W   = 7,
  parameter int unsigned DADD_W   = 10,
  parameter int unsigned SELC_NOP = 0,
  localparam int unsigned UW_W    = uw_w(SELA_W, SELB_W, SELC_W, TYPE_W, DADD_W)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [UW_W-1:0] UW_IN,
  input  logic            IN_VALID,
  output logic            IN_READY,
  output logic [UW_W-1:0] UW_OUT,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  input  logic            FLUSH,
  output logic [15:0]     ISSUE_CNT
`ifdef MIR_PARITY_EN
  ,
  input  logic            UW_PAR,
  output logic            PAR_ERR
`endif
);

  localparam logic [UW_MAX-1:0] NOP_FULL = nop_word(off_selc(DADD_W, TYPE_W),
                                                    SELC_W, SELC_NOP);
  localparam logic [UW_W-1:0]   NOP      = NOP_FULL[UW_W-1:0];

  mir_state_e      state_reg;
  logic            in_ready_reg;
  logic            out_valid_reg;
  logic [15:0]     cnt_reg;

  logic            in_beat;
  logic            out_beat;
  logic [UW_W-1:0] in_word;
  logic [UW_W-1:0] skid_q;
  logic [UW_W-1:0] out_q;
  logic [UW_W-1:0] out_d;

  logic            out_ld;
  logic            out_clr;
  logic            out_sel_skid;
  logic            skid_ld;
  logic            skid_clr;

  assign in_beat  = IN_VALID && in_ready_reg;
  assign out_beat = out_valid_reg && OUT_READY;

`ifdef MIR_PARITY_EN
  logic par_bad;
  logic par_err_reg;

  // Even parity: XOR of the word and its parity bit must be zero
  assign par_bad = (^UW_IN) ^ UW_PAR;
  assign in_word = par_bad ? NOP : UW_IN;

  // Sticky parity error, set only by a word that is actually accepted
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      par_err_reg <= 1'b0;
    end else if (in_beat && !FLUSH && par_bad) begin
      par_err_reg <= 1'b1;
    end
  end

  assign PAR_ERR = par_err_reg;
`else
  assign in_word = UW_IN;
`endif

  // Register-file control: which of output/skid loads, clears or shifts
  always_comb begin
    out_ld       = 1'b0;
    out_clr      = 1'b0;
    out_sel_skid = 1'b0;
    skid_ld      = 1'b0;
    skid_clr     = 1'b0;
    if (FLUSH) begin
      out_clr  = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (in_beat) out_ld = 1'b1;
        end
        ONE: begin
          if (in_beat) begin
            if (out_beat) out_ld  = 1'b1;
            else          skid_ld = 1'b1;
          end else if (out_beat) begin
            out_clr = 1'b1;
          end
        end
        FULL: begin
          if (out_beat) begin
            out_ld       = 1'b1;
            out_sel_skid = 1'b1;
            skid_clr     = 1'b1;
          end
        end
        default: begin
          out_clr  = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  assign out_d = out_sel_skid ? skid_q : in_word;

  mir_field_reg #(
    .W   (UW_W),
    .NOP (NOP)
  ) u_out_reg (
    .CLK (CLK),
    .RST (RST),
    .LD  (out_ld),
    .CLR (out_clr),
    .D   (out_d),
    .Q   (out_q)
  );

  mir_field_reg #(
    .W   (UW_W),
    .NOP (NOP)
  ) u_skid_reg (
    .CLK (CLK),
    .RST (RST),
    .LD  (skid_ld),
    .CLR (skid_clr),
    .D   (in_word),
    .Q   (skid_q)
  );

  // Occupancy FSM with registered IN_READY / OUT_VALID
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg     <= EMPTY;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else if (FLUSH) begin
      state_reg     <= EMPTY;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      in_ready_reg <= 1'b1;
      case (state_reg)
        EMPTY: begin
          if (in_beat) begin
            state_reg     <= ONE;
            out_valid_reg <= 1'b1;
          end
        end
        ONE: begin
          if (in_beat && !out_beat) begin
            state_reg    <= FULL;
            in_ready_reg <= 1'b0;
          end else if (!in_beat && out_beat) begin
            state_reg     <= EMPTY;
            out_valid_reg <= 1'b0;
          end
        end
        FULL: begin
          if (out_beat) begin
            state_reg <= ONE;
          end else begin
            in_ready_reg <= 1'b0;
          end
        end
        default: begin
          state_reg     <= EMPTY;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  // Issue counter: one per consumed microword, wraps, survives FLUSH
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_reg <= 16'd0;
    end else if (out_beat) begin
      cnt_reg <= cnt_reg + 16'd1;
    end
  end

  assign IN_READY  = in_ready_reg;
  assign OUT_VALID = out_valid_reg;
  assign UW_OUT    = out_q;
  assign ISSUE_CNT = cnt_reg;

endmodule

// File: doc/mir_pipe.md
MIR_PIPE -- requirements
Module: mir_pipe

Interface
REQ-001 The block SHALL have parameter SELA_W, default 5, meaning SelA field width.
REQ-002 The block SHALL have parameter SELB_W, default 6, meaning SelB field width.
REQ-003 The block SHALL have parameter SELC_W, default 6, meaning SelC field width.
REQ-004 The block SHALL have parameter TYPE_W, default 7, meaning Type field width.
REQ-005 The block SHALL have parameter DADD_W, default 10, meaning DAdd field width.
REQ-006 The block SHALL have parameter SELC_NOP, default 0, meaning the SelC code that writes no register.
REQ-007 The block SHALL define UW_W = 9+SELA_W+SELB_W+SELC_W+TYPE_W+DADD_W (43 by default).
REQ-008 The block SHALL have port CLK, input, 1, the single clock; all state changes on the rising edge.
REQ-009 The block SHALL have port RST, input, 1, the reset; asynchronous, active-high.
REQ-010 The block SHALL have port UW_IN, input, UW_W, the microword, packed MSB->LSB as ALUC[4], SH[2], KMux, MR, MW, SelA, SelB, SelC, Type, DAdd.
REQ-011 The block SHALL have port IN_VALID, input, 1, meaning UW_IN is valid.
REQ-012 The block SHALL have port IN_READY, output, 1, meaning the block can accept a word.
REQ-013 The block SHALL have port UW_OUT, output, UW_W, the registered microword to the datapath.
REQ-014 The block SHALL have port OUT_VALID, output, 1, meaning UW_OUT holds a real microword.
REQ-015 The block SHALL have port OUT_READY, input, 1, meaning the datapath consumes UW_OUT this cycle.
REQ-016 The block SHALL have port FLUSH, input, 1, which discards all buffered words (branch or abort).
REQ-017 The block SHALL have port ISSUE_CNT, output, 16, counting microwords consumed.

Function
REQ-018 The block SHALL be a 2-entry skid buffer with states EMPTY, ONE (output register full) and FULL (output plus skid register full).
REQ-019 A transfer SHALL occur on an input beat when IN_VALID && IN_READY, and on an output beat when OUT_VALID && OUT_READY.
REQ-020 IN_READY SHALL be registered and equal 1 exactly when the state is not FULL.
REQ-021 A word accepted in cycle N SHALL appear on UW_OUT with OUT_VALID=1 in cycle N+1 when the block was EMPTY, or when it was ONE with an output beat in cycle N.
REQ-022 Transitions SHALL be: EMPTY -> ONE on an input beat; ONE -> FULL on an input beat with no output beat; ONE -> EMPTY on an output beat with no input beat; ONE holds with both beats or neither; FULL -> ONE on an output beat, with the skid word moved into the output register; FULL otherwise holds.
REQ-023 Words SHALL leave in acceptance order, with none lost or duplicated.
REQ-024 When OUT_VALID=0, UW_OUT SHALL equal NOP: all fields zero except SelC=SELC_NOP; in particular MR=0 and MW=0.
REQ-025 While OUT_VALID=1 and OUT_READY=0, UW_OUT SHALL stay stable.
REQ-026 FLUSH SHALL force the state to EMPTY and UW_OUT to NOP on the next edge, dropping any input beat in the same cycle; FLUSH has priority over all other events.
REQ-027 ISSUE_CNT SHALL increment by 1 per output beat, wrap from 0xFFFF to 0, and not be cleared by FLUSH.

Reset
REQ-028 When RST=1 the block SHALL immediately set state EMPTY, UW_OUT=NOP, OUT_VALID=0, IN_READY=0, ISSUE_CNT=0 and PAR_ERR=0.
REQ-029 IN_READY SHALL rise on the first edge after RST falls.
REQ-030 A reset mid-transfer SHALL discard all buffered words.

Configuration
REQ-031 With macro MIR_PARITY_EN defined, the block SHALL add input UW_PAR (1, even parity over UW_IN) and output PAR_ERR (1).
REQ-032 With MIR_PARITY_EN defined, an accepted word whose parity mismatches SHALL be stored as NOP with OUT_VALID=1 and SHALL set PAR_ERR, which stays set until reset.
REQ-033 Without MIR_PARITY_EN, the block SHALL have no UW_PAR or PAR_ERR ports and SHALL add no parity logic.

Structure
REQ-034 Package mir_pkg SHALL hold the field widths, the UW_W function, field offset constants, the state enum (EMPTY/ONE/FULL) and the NOP builder function.
REQ-035 Sub-module mir_field_reg (a parametrised UW_W-wide register with load enable and async clear-to-NOP) SHALL be used for both the output and skid registers.

Verification
REQ-036 A bench SHALL drive RST pulse mid-stream with 2 words buffered -> OUT_VALID=0, UW_OUT=NOP (SelC=0) asynchronously, ISSUE_CNT=0.
REQ-037 A bench SHALL stream 8 words with OUT_READY=1 constantly -> each appears 1 cycle later, in order, ISSUE_CNT=8, IN_READY never drops.
REQ-038 A bench SHALL hold OUT_READY=0 while sending words A, B, C -> A held on UW_OUT, B in skid, IN_READY=0, C not accepted; OUT_READY=1 then delivers A, B, C in order.
REQ-039 A bench SHALL assert FLUSH in FULL with IN_VALID=1 -> next cycle EMPTY, OUT_VALID=0, MR=MW=0, input word dropped, ISSUE_CNT unchanged.
REQ-040 A bench SHALL preset ISSUE_CNT to 0xFFFF via 65535 beats, then perform 1 more beat -> 0x0000.
REQ-041 With MIR_PARITY_EN, a bench SHALL send a word 0x7FF_FFFF_FFFF with UW_PAR=0 (mismatch) -> UW_OUT=NOP, PAR_ERR=1 sticky through later good words.
